fifo_rd_stream: RTL and testbench
=================================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, which is the width of FIFO read data and stream data.
REQ-002 The module SHALL have parameter CNT_WIDTH, default 16, which is the width of the delivered-word counter.
REQ-003 Port rclk SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rrst SHALL be an input, 1 bit: reset, asynchronous, active-high.
REQ-005 Port rempty SHALL be an input, 1 bit: FIFO read-side empty flag, registered-derived.
REQ-006 Port rdata SHALL be an input, DATA_WIDTH bits: FIFO word at the current read address, valid whenever rempty=0.
REQ-007 Port rinc SHALL be an output, 1 bit: FIFO pop request, sampled by the FIFO read pointer on rclk.
REQ-008 Port flush SHALL be an input, 1 bit: discard all buffered words.
REQ-009 Port out_ready SHALL be an input, 1 bit: downstream accepts out_data this cycle.
REQ-010 Port out_valid SHALL be an output, 1 bit: out_data holds a valid word.
REQ-011 Port out_data SHALL be an output, DATA_WIDTH bits: head word of the buffer.
REQ-012 Port pop_cnt SHALL be an output, CNT_WIDTH bits: count of completed output handshakes.

Function
REQ-013 The block SHALL hold a 2-entry in-order buffer with a 1-bit head index, a 1-bit tail index and a 2-bit occupancy count (0..2).
REQ-014 rinc SHALL be combinational: rinc = !rempty && !flush && (count < 2).
REQ-015 On a cycle with rinc=1, rdata SHALL be written into entry[tail], and tail SHALL toggle.
REQ-016 out_valid SHALL equal (count != 0), and out_data SHALL equal entry[head]; both are register-derived, with no combinational path from out_ready.
REQ-017 On a cycle with out_valid && out_ready, head SHALL toggle and pop_cnt SHALL increment by 1, wrapping modulo 2^CNT_WIDTH.
REQ-018 On a cycle with a push and a pop together, count SHALL be unchanged; push only increments it; pop only decrements it.
REQ-019 The latency from a push at cycle N to out_valid=1 SHALL be 1 cycle, i.e. visible at N+1 when the buffer was empty.
REQ-020 Sustained throughput SHALL be 1 word/cycle whenever rempty=0 and out_ready=1.
REQ-021 A push when count=2 SHALL be impossible, because rinc is gated; the bench asserts this never occurs.
REQ-022 When flush=1, the next state SHALL be count=0 with head=tail=0; rinc=0 that cycle; entry contents are don't-care.
REQ-023 When flush=1 together with out_valid && out_ready, the handshake SHALL complete (pop_cnt increments) and the remaining entries are discarded.
REQ-024 The block SHALL NOT reorder, duplicate or drop words except under flush.
REQ-025 out_data SHALL hold stable while out_valid=1 and out_ready=0.

Reset
REQ-026 Asserting rrst SHALL immediately clear count, head, tail and pop_cnt to 0, and therefore out_valid to 0; entry registers SHALL reset to 0.
REQ-027 While rrst=1, rinc SHALL be 0 regardless of rempty.
REQ-028 If reset asserts mid-stream, any buffered words SHALL be lost; after release, operation SHALL resume from the empty state on the first rclk edge.

Structure
REQ-029 A shared package fifo_rd_stream_pkg SHALL hold BUF_DEPTH=2, the count width constant (2) and the default DATA_WIDTH/CNT_WIDTH values.
REQ-030 The 2-entry storage plus head/tail/count SHALL be implemented as the sub-module rd_stream_buf; fifo_rd_stream adds the rinc gating, flush handling and pop_cnt.

Verification
REQ-031 Reset test: hold rrst=1 with rempty=0 -> rinc=0, out_valid=0, pop_cnt=0; release -> rinc=1 on the first cycle.
REQ-032 Streaming test: FIFO holds 0x11,0x22,0x33 and out_ready=1 -> out_data is 0x11,0x22,0x33 on consecutive cycles starting 1 cycle after the first rinc; pop_cnt=3.
REQ-033 Backpressure test: FIFO holds 0xA0..0xA4 and out_ready=0 -> exactly 2 rinc pulses, out_data stays 0xA0; then set out_ready=1 -> all 5 words arrive in order.
REQ-034 Flush test: count=2 holding 0x55,0x66 with out_ready=1, assert flush for 1 cycle -> 0x55 is delivered, pop_cnt increments by 1, 0x66 is discarded, out_valid=0 next cycle, rinc=0 during flush.
REQ-035 Wrap test: preload pop_cnt via 65535 handshakes, then do 1 more -> pop_cnt=0.
REQ-036 Empty-edge test: rempty toggles 1/0 each cycle with out_ready=1 -> rinc is asserted only on cycles with rempty=0, and there are no duplicate words.

Source files
------------

// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants and helpers for the FIFO read-side stream adapter.
// Buffer depth, occupancy width and default widths live here.
package fifo_rd_stream_pkg;

  localparam int BUF_DEPTH      = 2;
  localparam int OCC_WIDTH      = 2;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CNT_WIDTH  = 16;

  typedef logic [OCC_WIDTH-1:0] occ_t;

  localparam occ_t OCC_ONE  = occ_t'(1);
  localparam occ_t OCC_FULL = occ_t'(BUF_DEPTH);

  function automatic logic occ_full(occ_t c);
    return c == OCC_FULL;
  endfunction

endpackage

// File: rtl/rd_stream_buf.sv
// Two-entry in-order skid buffer with head/tail indices.
// Head word and valid are taken straight from registers.
module rd_stream_buf
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  valid,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] entry [BUF_DEPTH];
  logic                  head;
  logic                  tail;
  occ_t                  count;
  logic                  do_pop;

  assign do_pop = pop && valid;
  assign valid  = count != '0;
  assign full   = occ_full(count);
  assign rdata  = entry[head];

  // Storage writes at tail; clear only rewinds the indices.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        entry[i] <= '0;
      end
    end else if (push && !clear) begin
      entry[tail] <= wdata;
    end
  end

  // Head, tail and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= '0;
    end else if (clear) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= ~tail;
      end
      if (do_pop) begin
        head <= ~head;
      end
      unique case ({push, do_pop})
        2'b10:   count <= count + OCC_ONE;
        2'b01:   count <= count - OCC_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Turns a FIFO read port into a valid/ready stream.
// Pops are gated by buffer space, flush and reset.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  input  logic                  flush,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  pop_cnt
);

  logic full;
  logic handshake;

  assign handshake = out_valid && out_ready;
  assign rinc      = !rrst && !rempty && !flush && !full;

  rd_stream_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk  (rclk),
    .rst  (rrst),
    .clear(flush),
    .push (rinc),
    .pop  (handshake),
    .wdata(rdata),
    .valid(out_valid),
    .full (full),
    .rdata(out_data)
  );

  // Count completed output handshakes, wrapping naturally.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      pop_cnt <= '0;
    end else if (handshake) begin
      pop_cnt <= pop_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: a FIFO model feeds the read
// port, a monitor checks every delivered word against a queue.
module tb_fifo_rd_stream;

  logic        rclk;
  logic        rrst;
  logic        rempty;
  logic [7:0]  rdata;
  logic        rinc;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [15:0] pop_cnt;

  fifo_rd_stream #(
    .DATA_WIDTH(8),
    .CNT_WIDTH (16)
  ) dut (
    .rclk     (rclk),
    .rrst     (rrst),
    .rempty   (rempty),
    .rdata    (rdata),
    .rinc     (rinc),
    .flush    (flush),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .pop_cnt  (pop_cnt)
  );

  logic [7:0] fq[$];
  logic [7:0] exq[$];
  logic       force_empty;
  int         errors;
  int         checks;
  int         rinc_pulses;
  int         cyc;

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  always @(posedge rclk) cyc++;

  task automatic refresh();
    rempty = force_empty || (fq.size() == 0);
    rdata  = (fq.size() != 0) ? fq[0] : 8'h00;
  endtask

  task automatic load(input logic [7:0] w);
    fq.push_back(w);
    exq.push_back(w);
    refresh();
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drain(input int max);
    checks++;
    for (int i = 0; i < max; i++) begin
      @(negedge rclk);
      if (exq.size() == 0 && !out_valid && fq.size() == 0) return;
    end
    errors++;
    $display("FAIL drain_timeout: %0d words left expected 0", exq.size());
  endtask

  // FIFO model: pop the head word after each accepted rinc.
  always @(posedge rclk) begin
    logic took;
    took = rinc && !rrst;
    if (took && dut.u_buf.count == 2'd2) begin
      errors++;
      $display("FAIL push_when_full: count %0d expected <2", dut.u_buf.count);
    end
    if (took) rinc_pulses++;
    #1;
    if (took) begin
      if (fq.size() == 0) begin
        errors++;
        $display("FAIL fifo_underflow: size 0 expected >0");
      end else begin
        void'(fq.pop_front());
      end
    end
    refresh();
  end

  // Monitor: order, duplication and stall-stability checks.
  logic       hold_v;
  logic [7:0] hold_d;
  always @(posedge rclk) begin
    logic [7:0] e;
    if (rrst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && out_valid) begin
        checks++;
        if (out_data !== hold_d) begin
          errors++;
          $display("FAIL stall_stable: got %0h expected %0h", out_data, hold_d);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exq.size() == 0) begin
          errors++;
          $display("FAIL extra_word: got %0h expected none", out_data);
        end else begin
          e = exq.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL word_order: got %0h expected %0h", out_data, e);
          end
        end
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int c0;
    errors = 0;
    checks = 0;
    rinc_pulses = 0;
    cyc = 0;
    hold_v = 1'b0;
    hold_d = 8'h00;
    force_empty = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    rrst = 1'b1;

    // Reset with a non-empty FIFO, then stream three words.
    load(8'h11);
    load(8'h22);
    load(8'h33);
    repeat (3) @(negedge rclk);
    chk("rst_rinc", {31'd0, rinc}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_popcnt", {16'd0, pop_cnt}, 32'd0);
    rrst = 1'b0;
    #1;
    chk("rel_rinc", {31'd0, rinc}, 32'd1);
    @(negedge rclk);
    chk("stream_v0", {31'd0, out_valid}, 32'd1);
    chk("stream_d0", {24'd0, out_data}, 32'h11);
    @(negedge rclk);
    chk("stream_d1", {24'd0, out_data}, 32'h22);
    @(negedge rclk);
    chk("stream_d2", {24'd0, out_data}, 32'h33);
    @(negedge rclk);
    chk("stream_done", {31'd0, out_valid}, 32'd0);
    chk("stream_cnt", {16'd0, pop_cnt}, 32'd3);

    // Backpressure: only two words may be pulled from the FIFO.
    out_ready = 1'b0;
    p0 = rinc_pulses;
    for (int i = 0; i < 5; i++) load(8'hA0 + 8'(i));
    repeat (6) @(negedge rclk);
    chk("bp_pulses", rinc_pulses - p0, 32'd2);
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_head", {24'd0, out_data}, 32'hA0);
    out_ready = 1'b1;
    drain(20);
    chk("bp_cnt", {16'd0, pop_cnt}, 32'd8);

    // Flush with a full buffer while the head is accepted.
    out_ready = 1'b0;
    load(8'h55);
    load(8'h66);
    repeat (3) @(negedge rclk);
    chk("fl_head", {24'd0, out_data}, 32'h55);
    load(8'h77);
    flush = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("fl_rinc_full", {31'd0, rinc}, 32'd0);
    @(negedge rclk);
    exq.delete(0);
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_cnt", {16'd0, pop_cnt}, 32'd9);
    chk("fl_rinc_empty", {31'd0, rinc}, 32'd0);
    @(negedge rclk);
    flush = 1'b0;
    #1;
    chk("fl_after_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_after_rinc", {31'd0, rinc}, 32'd1);
    drain(20);
    chk("fl_end_cnt", {16'd0, pop_cnt}, 32'd10);

    // Long burst: full throughput and counter wrap.
    c0 = cyc;
    for (int i = 0; i < 65525; i++) load(8'(i));
    drain(70000);
    chk("tput_cycles", cyc - c0, 32'd65526);
    chk("wrap_max", {16'd0, pop_cnt}, 32'd65535);
    load(8'h5A);
    drain(20);
    chk("wrap_zero", {16'd0, pop_cnt}, 32'd0);

    // Empty flag toggling every cycle.
    for (int i = 0; i < 4; i++) load(8'hC0 + 8'(i));
    for (int i = 0; i < 12; i++) begin
      @(negedge rclk);
      force_empty = ~force_empty;
      refresh();
      #1;
      checks++;
      if (rinc && rempty) begin
        errors++;
        $display("FAIL rinc_on_empty: rinc 1 expected 0");
      end
    end
    force_empty = 1'b0;
    refresh();
    drain(20);
    chk("edge_cnt", {16'd0, pop_cnt}, 32'd4);

    // Reset mid-stream loses the buffered words.
    out_ready = 1'b0;
    load(8'hE0);
    load(8'hE1);
    load(8'hE2);
    repeat (3) @(negedge rclk);
    rrst = 1'b1;
    exq.delete(0);
    exq.delete(0);
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_cnt", {16'd0, pop_cnt}, 32'd0);
    chk("mid_rst_rinc", {31'd0, rinc}, 32'd0);
    @(negedge rclk);
    rrst = 1'b0;
    out_ready = 1'b1;
    drain(20);
    chk("mid_rst_end", {16'd0, pop_cnt}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
